// File: rtl/ma_stage_if.sv
// ---------------------------------------------------------------------------
// ma_stage_if
// Data-memory request/ready bus between the memory-access stage and the
// data memory.
//
// Signals:
//   mem_req    master->slave  request valid (held until mem_ready)
//   mem_we     master->slave  1 = store, 0 = load
//   mem_addr   master->slave  word address
//   mem_wdata  master->slave  store data
//   mem_ready  slave->master  request completes this cycle
//   mem_rdata  slave->master  load data, valid in the mem_ready cycle
// ---------------------------------------------------------------------------
interface ma_stage_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  // Pipeline side: issues requests.
  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  // Memory side: answers requests.
  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/ma_stage.sv
// ---------------------------------------------------------------------------
// ma_stage
// Memory-access stage of the 5-stage pipeline, between the EX/MA and MA/WB
// latches. ALU-only instructions pass straight through to the MA/WB latch in
// one cycle. Aligned loads/stores are captured into hold registers and a
// request is issued on the data-memory bus; the stage stalls upstream until
// the memory answers (or a timeout aborts the access). Misaligned accesses
// are never issued; they retire with writeback suppressed and an error pulse.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid .. in_rd     instruction fields from the EX/MA latch
//   ma_stall              hold the EX/MA latch and earlier stages
//   mem (master modport)  data-memory request/ready bus
//   wb_valid .. wb_rd     registered MA/WB latch contents
//   mem_err               one-cycle pulse on misalignment or timeout
//
// Parameters:
//   XLEN     datapath / address width
//   RD_W     destination register index width
//   TIMEOUT  max BUSY cycles without mem_ready before abort (0 = never)
// ---------------------------------------------------------------------------
module ma_stage #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_op2,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_isLd,
  input  logic            in_isSt,
  input  logic            in_isCall,
  input  logic            in_isWb,
  input  logic [RD_W-1:0] in_rd,

  output logic            ma_stall,

  ma_stage_if.master      mem,

  output logic            wb_valid,
  output logic [XLEN-1:0] wb_alu,
  output logic [XLEN-1:0] wb_ld,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_isLd,
  output logic            wb_isCall,
  output logic            wb_isWb,
  output logic [RD_W-1:0] wb_rd,

  output logic            mem_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // Counter only needs to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit              TO_EN    = (TIMEOUT != 0);

  // Instruction fields that travel together through the hold registers.
  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] pc;
    logic            isLd;
    logic            isSt;
    logic            isCall;
    logic            isWb;
    logic [RD_W-1:0] rd;
  } ins_t;

  logic [0:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  ins_t             hold_q,    hold_d;

  logic             wb_valid_q,  wb_valid_d;
  logic [XLEN-1:0]  wb_alu_q,    wb_alu_d;
  logic [XLEN-1:0]  wb_ld_q,     wb_ld_d;
  logic [XLEN-1:0]  wb_pc_q,     wb_pc_d;
  logic             wb_isLd_q,   wb_isLd_d;
  logic             wb_isCall_q, wb_isCall_d;
  logic             wb_isWb_q,   wb_isWb_d;
  logic [RD_W-1:0]  wb_rd_q,     wb_rd_d;
  logic             err_q,       err_d;

  ins_t             in_ins;
  logic             busy;
  logic             mem_op;
  logic             misaligned;
  logic             timeout_hit;

  assign in_ins = '{
    alu:    in_alu,
    op2:    in_op2,
    pc:     in_pc,
    isLd:   in_isLd,
    isSt:   in_isSt,
    isCall: in_isCall,
    isWb:   in_isWb,
    rd:     in_rd
  };

  assign busy        = (state_q == S_BUSY);
  assign mem_op      = in_valid & (in_isLd | in_isSt);
  assign misaligned  = (in_alu[1:0] != 2'b00);
  assign timeout_hit = TO_EN && (cnt_q == CNT_LAST);

  // Bus outputs come straight from state and hold registers so they are
  // stable for the whole BUSY period and collapse to 0 the instant reset
  // clears state_q/hold_q.
  assign mem.mem_req   = busy;
  assign mem.mem_we    = hold_q.isSt;
  assign mem.mem_addr  = hold_q.alu;
  assign mem.mem_wdata = hold_q.op2;

  // Stall covers the completion cycle too, so the instruction waiting in
  // EX/MA is accepted in the first IDLE cycle (one bubble).
  assign ma_stall = busy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    wb_valid_d  = 1'b0;
    wb_alu_d    = wb_alu_q;
    wb_ld_d     = wb_ld_q;
    wb_pc_d     = wb_pc_q;
    wb_isLd_d   = wb_isLd_q;
    wb_isCall_d = wb_isCall_q;
    wb_isWb_d   = wb_isWb_q;
    wb_rd_d     = wb_rd_q;
    err_d       = 1'b0;

    if (!busy) begin
      if (in_valid) begin
        if (mem_op && !misaligned) begin
          hold_d  = in_ins;
          cnt_d   = '0;
          state_d = S_BUSY;
        end else begin
          // Non-memory op, or a misaligned access retired without a request.
          wb_valid_d  = 1'b1;
          wb_alu_d    = in_alu;
          wb_ld_d     = '0;
          wb_pc_d     = in_pc;
          wb_isLd_d   = in_isLd;
          wb_isCall_d = in_isCall;
          wb_isWb_d   = in_isWb & ~mem_op;
          wb_rd_d     = in_rd;
          err_d       = mem_op;
        end
      end
    end else begin
      if (mem.mem_ready) begin
        // Completion takes priority over a coincident timeout.
        wb_valid_d  = 1'b1;
        wb_alu_d    = hold_q.alu;
        wb_ld_d     = hold_q.isLd ? mem.mem_rdata : '0;
        wb_pc_d     = hold_q.pc;
        wb_isLd_d   = hold_q.isLd;
        wb_isCall_d = hold_q.isCall;
        wb_isWb_d   = hold_q.isWb;
        wb_rd_d     = hold_q.rd;
        state_d     = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          // Abort: retire the instruction with its register write killed.
          wb_valid_d  = 1'b1;
          wb_alu_d    = hold_q.alu;
          wb_ld_d     = '0;
          wb_pc_d     = hold_q.pc;
          wb_isLd_d   = hold_q.isLd;
          wb_isCall_d = hold_q.isCall;
          wb_isWb_d   = 1'b0;
          wb_rd_d     = hold_q.rd;
          err_d       = 1'b1;
          state_d     = S_IDLE;
        end
      end
    end
  end

  // ---- MA/WB register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_alu_q    <= '0;
      wb_ld_q     <= '0;
      wb_pc_q     <= '0;
      wb_isLd_q   <= 1'b0;
      wb_isCall_q <= 1'b0;
      wb_isWb_q   <= 1'b0;
      wb_rd_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      wb_valid_q  <= wb_valid_d;
      wb_alu_q    <= wb_alu_d;
      wb_ld_q     <= wb_ld_d;
      wb_pc_q     <= wb_pc_d;
      wb_isLd_q   <= wb_isLd_d;
      wb_isCall_q <= wb_isCall_d;
      wb_isWb_q   <= wb_isWb_d;
      wb_rd_q     <= wb_rd_d;
      err_q       <= err_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_alu    = wb_alu_q;
  assign wb_ld     = wb_ld_q;
  assign wb_pc     = wb_pc_q;
  assign wb_isLd   = wb_isLd_q;
  assign wb_isCall = wb_isCall_q;
  assign wb_isWb   = wb_isWb_q;
  assign wb_rd     = wb_rd_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_ma_stage.sv
// ---------------------------------------------------------------------------
// tb_ma_stage
// Directed, table-driven bench for ma_stage (TIMEOUT = 4). Inputs are driven
// and outputs sampled on the falling clock edge. Each table row gives the
// inputs for one cycle, the expected combinational bus/stall outputs in that
// cycle, and the expected registered MA/WB outputs after the next rising edge.
// A hand-written sequence covers the call and the asynchronous reset that
// arrives in the middle of a memory request.
// ---------------------------------------------------------------------------
module tb_ma_stage;
  localparam int XLEN = 32;
  localparam int RD_W = 4;
  localparam int TO   = 4;
  localparam int NV   = 25;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [XLEN-1:0] in_alu, in_op2, in_pc;
  logic            in_isLd, in_isSt, in_isCall, in_isWb;
  logic [RD_W-1:0] in_rd;
  logic            ma_stall;
  logic            wb_valid;
  logic [XLEN-1:0] wb_alu, wb_ld, wb_pc;
  logic            wb_isLd, wb_isCall, wb_isWb;
  logic [RD_W-1:0] wb_rd;
  logic            mem_err;

  ma_stage_if #(.XLEN(XLEN)) mif ();

  ma_stage #(.XLEN(XLEN), .RD_W(RD_W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_alu    (in_alu),
    .in_op2    (in_op2),
    .in_pc     (in_pc),
    .in_isLd   (in_isLd),
    .in_isSt   (in_isSt),
    .in_isCall (in_isCall),
    .in_isWb   (in_isWb),
    .in_rd     (in_rd),
    .ma_stall  (ma_stall),
    .mem       (mif),
    .wb_valid  (wb_valid),
    .wb_alu    (wb_alu),
    .wb_ld     (wb_ld),
    .wb_pc     (wb_pc),
    .wb_isLd   (wb_isLd),
    .wb_isCall (wb_isCall),
    .wb_isWb   (wb_isWb),
    .wb_rd     (wb_rd),
    .mem_err   (mem_err)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s [%0d]: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  typedef struct packed {
    // inputs
    logic        vld;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [31:0] pc;
    logic        ld;
    logic        st;
    logic        call;
    logic        wb;
    logic [3:0]  rd;
    logic        rdy;
    logic [31:0] rdata;
    // expected in the same cycle
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic        chk_bus;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    // expected after the rising edge
    logic        e_valid;
    logic [31:0] e_alu;
    logic [31:0] e_ld;
    logic [31:0] e_pc;
    logic        e_isLd;
    logic        e_isCall;
    logic        e_isWb;
    logic [3:0]  e_rd;
    logic        e_err;
  } vec_t;

  vec_t vecs [0:NV-1];

  task automatic drive(input vec_t v);
    in_valid      = v.vld;
    in_alu        = v.alu;
    in_op2        = v.op2;
    in_pc         = v.pc;
    in_isLd       = v.ld;
    in_isSt       = v.st;
    in_isCall     = v.call;
    in_isWb       = v.wb;
    in_rd         = v.rd;
    mif.mem_ready = v.rdy;
    mif.mem_rdata = v.rdata;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_alu = '0; in_op2 = '0; in_pc = '0;
    in_isLd = 1'b0; in_isSt = 1'b0; in_isCall = 1'b0; in_isWb = 1'b0; in_rd = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          vld   alu          op2         pc           ld   st   call wb   rd    rdy  rdata
    //          stall req  we   chkb addr        wdata
    //          valid alu          ld           pc           isLd call isWb rd    err
    // Three ALU ops back to back
    vecs[0]  = '{1'b1,32'h10,32'h0,32'h1000,1'b0,1'b0,1'b0,1'b1,4'd1,1'b1,32'hBAD0BAD0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b1,32'h10,32'h0,32'h1000,1'b0,1'b0,1'b1,4'd1,1'b0};
    vecs[1]  = '{1'b1,32'h20,32'h0,32'h1004,1'b0,1'b0,1'b0,1'b1,4'd2,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b1,32'h20,32'h0,32'h1004,1'b0,1'b0,1'b1,4'd2,1'b0};
    vecs[2]  = '{1'b1,32'h30,32'h0,32'h1008,1'b0,1'b0,1'b0,1'b1,4'd3,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b1,32'h30,32'h0,32'h1008,1'b0,1'b0,1'b1,4'd3,1'b0};
    // Load 0x100 accepted; inputs then change (must be ignored); ready on 3rd BUSY cycle
    vecs[3]  = '{1'b1,32'h100,32'h0,32'h100C,1'b1,1'b0,1'b0,1'b1,4'd4,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h30,32'h0,32'h1008,1'b0,1'b0,1'b1,4'd3,1'b0};
    vecs[4]  = '{1'b1,32'h999,32'h77,32'h2000,1'b0,1'b1,1'b1,1'b1,4'd9,1'b0,32'h0,
                 1'b1,1'b1,1'b0,1'b1,32'h100,32'h0,
                 1'b0,32'h30,32'h0,32'h1008,1'b0,1'b0,1'b1,4'd3,1'b0};
    vecs[5]  = '{1'b1,32'h999,32'h77,32'h2000,1'b0,1'b1,1'b1,1'b1,4'd9,1'b0,32'h0,
                 1'b1,1'b1,1'b0,1'b1,32'h100,32'h0,
                 1'b0,32'h30,32'h0,32'h1008,1'b0,1'b0,1'b1,4'd3,1'b0};
    vecs[6]  = '{1'b1,32'h999,32'h77,32'h2000,1'b0,1'b1,1'b1,1'b1,4'd9,1'b1,32'hDEADBEEF,
                 1'b1,1'b1,1'b0,1'b1,32'h100,32'h0,
                 1'b1,32'h100,32'hDEADBEEF,32'h100C,1'b1,1'b0,1'b1,4'd4,1'b0};
    // Next instruction accepted in the first IDLE cycle
    vecs[7]  = '{1'b1,32'h40,32'h0,32'h1010,1'b0,1'b0,1'b0,1'b1,4'd5,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b1,32'h40,32'h0,32'h1010,1'b0,1'b0,1'b1,4'd5,1'b0};
    // Store 0x204 / 0x55AA, ready on 2nd BUSY cycle (rdata must not reach wb_ld)
    vecs[8]  = '{1'b1,32'h204,32'h55AA,32'h1014,1'b0,1'b1,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h40,32'h0,32'h1010,1'b0,1'b0,1'b1,4'd5,1'b0};
    vecs[9]  = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b1,1'b1,1'b1,1'b1,32'h204,32'h55AA,
                 1'b0,32'h40,32'h0,32'h1010,1'b0,1'b0,1'b1,4'd5,1'b0};
    vecs[10] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1,32'h1234,
                 1'b1,1'b1,1'b1,1'b1,32'h204,32'h55AA,
                 1'b1,32'h204,32'h0,32'h1014,1'b0,1'b0,1'b0,4'd0,1'b0};
    // Misaligned load 0x102: no request, error pulse, writeback killed
    vecs[11] = '{1'b1,32'h102,32'h0,32'h1018,1'b1,1'b0,1'b0,1'b1,4'd6,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b1,32'h102,32'h0,32'h1018,1'b1,1'b0,1'b0,4'd6,1'b1};
    // Idle with a stray mem_ready: ignored, fields hold, error cleared
    vecs[12] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1,32'hFFFF0000,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h102,32'h0,32'h1018,1'b1,1'b0,1'b0,4'd6,1'b0};
    // Load 0x300, never ready: timeout after 4 BUSY cycles
    vecs[13] = '{1'b1,32'h300,32'h0,32'h101C,1'b1,1'b0,1'b0,1'b1,4'd7,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h102,32'h0,32'h1018,1'b1,1'b0,1'b0,4'd6,1'b0};
    vecs[14] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b1,1'b1,1'b0,1'b1,32'h300,32'h0,
                 1'b0,32'h102,32'h0,32'h1018,1'b1,1'b0,1'b0,4'd6,1'b0};
    vecs[15] = vecs[14];
    vecs[16] = vecs[14];
    vecs[17] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b1,1'b1,1'b0,1'b1,32'h300,32'h0,
                 1'b1,32'h300,32'h0,32'h101C,1'b1,1'b0,1'b0,4'd7,1'b1};
    vecs[18] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h300,32'h0,32'h101C,1'b1,1'b0,1'b0,4'd7,1'b0};
    // Load 0x400, ready in the 4th (timeout) cycle: completion wins
    vecs[19] = '{1'b1,32'h400,32'h0,32'h1020,1'b1,1'b0,1'b0,1'b1,4'd8,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h300,32'h0,32'h101C,1'b1,1'b0,1'b0,4'd7,1'b0};
    vecs[20] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b1,1'b1,1'b0,1'b1,32'h400,32'h0,
                 1'b0,32'h300,32'h0,32'h101C,1'b1,1'b0,1'b0,4'd7,1'b0};
    vecs[21] = vecs[20];
    vecs[22] = vecs[20];
    vecs[23] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b1,32'hCAFEF00D,
                 1'b1,1'b1,1'b0,1'b1,32'h400,32'h0,
                 1'b1,32'h400,32'hCAFEF00D,32'h1020,1'b1,1'b0,1'b1,4'd8,1'b0};
    vecs[24] = '{1'b0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,1'b0,4'd0,1'b0,32'h0,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,
                 1'b0,32'h400,32'hCAFEF00D,32'h1020,1'b1,1'b0,1'b1,4'd8,1'b0};

    // Reset
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1 ("rst_wb_valid", 0, wb_valid, 1'b0);
    chk1 ("rst_mem_req",  0, mif.mem_req, 1'b0);
    chk1 ("rst_mem_we",   0, mif.mem_we, 1'b0);
    chk1 ("rst_stall",    0, ma_stall, 1'b0);
    chk1 ("rst_mem_err",  0, mem_err, 1'b0);
    chk32("rst_wb_alu",   0, wb_alu, 32'h0);
    chk32("rst_wb_pc",    0, wb_pc, 32'h0);
    chk32("rst_wb_ld",    0, wb_ld, 32'h0);

    // Table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk1("stall", i, ma_stall, vecs[i].e_stall);
      chk1("req",   i, mif.mem_req, vecs[i].e_req);
      if (vecs[i].chk_bus) begin
        chk1 ("we",    i, mif.mem_we, vecs[i].e_we);
        chk32("addr",  i, mif.mem_addr, vecs[i].e_addr);
        chk32("wdata", i, mif.mem_wdata, vecs[i].e_wdata);
      end
      @(negedge clk);
      chk1 ("wb_valid",  i, wb_valid, vecs[i].e_valid);
      chk32("wb_alu",    i, wb_alu, vecs[i].e_alu);
      chk32("wb_ld",     i, wb_ld, vecs[i].e_ld);
      chk32("wb_pc",     i, wb_pc, vecs[i].e_pc);
      chk1 ("wb_isLd",   i, wb_isLd, vecs[i].e_isLd);
      chk1 ("wb_isCall", i, wb_isCall, vecs[i].e_isCall);
      chk1 ("wb_isWb",   i, wb_isWb, vecs[i].e_isWb);
      chk32("wb_rd",     i, {28'h0, wb_rd}, {28'h0, vecs[i].e_rd});
      chk1 ("mem_err",   i, mem_err, vecs[i].e_err);
    end

    // Call, then a load interrupted by asynchronous reset mid-BUSY
    idle_inputs();
    in_valid = 1'b1; in_alu = 32'h44; in_pc = 32'h40; in_isCall = 1'b1; in_isWb = 1'b1; in_rd = 4'd15;
    @(negedge clk);
    chk1 ("call_valid", 100, wb_valid, 1'b1);
    chk1 ("call_flag",  100, wb_isCall, 1'b1);
    chk32("call_pc",    100, wb_pc, 32'h40);
    chk32("call_rd",    100, {28'h0, wb_rd}, 32'hF);

    idle_inputs();
    in_valid = 1'b1; in_alu = 32'h500; in_pc = 32'h44; in_isLd = 1'b1; in_isWb = 1'b1; in_rd = 4'd2;
    @(negedge clk);
    idle_inputs();
    chk1 ("busy_req",   101, mif.mem_req, 1'b1);
    chk1 ("busy_stall", 101, ma_stall, 1'b1);
    chk32("busy_addr",  101, mif.mem_addr, 32'h500);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("arst_req",    102, mif.mem_req, 1'b0);
    chk1 ("arst_stall",  102, ma_stall, 1'b0);
    chk1 ("arst_we",     102, mif.mem_we, 1'b0);
    chk1 ("arst_valid",  102, wb_valid, 1'b0);
    chk1 ("arst_call",   102, wb_isCall, 1'b0);
    chk32("arst_pc",     102, wb_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1 ("post_rst_req", 103, mif.mem_req, 1'b0);

    // Stage is usable again after reset
    in_valid = 1'b1; in_alu = 32'h77; in_pc = 32'h48; in_isWb = 1'b1; in_rd = 4'd3;
    @(negedge clk);
    idle_inputs();
    chk1 ("post_rst_valid", 104, wb_valid, 1'b1);
    chk32("post_rst_alu",   104, wb_alu, 32'h77);
    chk1 ("post_rst_stall", 104, ma_stall, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
